// File: rtl/nvram_upload_server.sv
// HPS upload server for the CMOS NVRAM: packs two 4-bit cells per ioctl byte
// and tracks CPU writes to CMOS so the top level can prompt a save.
module nvram_upload_server #(
    parameter int unsigned CELL_AW      = 10,
    parameter logic [15:0] UPLOAD_INDEX = 16'd4
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               ioctl_upload,
    input  logic [15:0]        ioctl_index,
    input  logic               ioctl_rd,
    input  logic [24:0]        ioctl_addr,
    output logic [7:0]         ioctl_din,
    output logic               ioctl_wait,
    output logic               mem_req,
    output logic [CELL_AW-1:0] mem_addr,
    input  logic               mem_ack,
    input  logic [3:0]         mem_rdata,
    input  logic               cpu_cmos_we,
    output logic               nvram_dirty
);

    localparam int unsigned BW = CELL_AW - 1;

    typedef enum logic [1:0] {
        IDLE,
        FETCH_LO,
        FETCH_HI,
        DONE
    } state_t;

    state_t            state, state_n;
    logic [BW-1:0]     byte_addr, byte_addr_n;
    logic [3:0]        lo, lo_n;
    logic              abort, abort_n;
    logic [7:0]        din_n;
    logic              wait_n;
    logic              req_n;
    logic [CELL_AW-1:0] addr_n;
    logic              dirty_n;

    logic active;
    logic in_range;
    logic ack;

    assign active   = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
    assign in_range = (ioctl_addr[24:BW] == '0);
    assign ack      = mem_ack && mem_req;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state       <= IDLE;
            byte_addr   <= '0;
            lo          <= '0;
            abort       <= 1'b0;
            ioctl_din   <= 8'h00;
            ioctl_wait  <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            nvram_dirty <= 1'b0;
        end else begin
            state       <= state_n;
            byte_addr   <= byte_addr_n;
            lo          <= lo_n;
            abort       <= abort_n;
            ioctl_din   <= din_n;
            ioctl_wait  <= wait_n;
            mem_req     <= req_n;
            mem_addr    <= addr_n;
            nvram_dirty <= dirty_n;
        end
    end

    always_comb begin
        state_n     = state;
        byte_addr_n = byte_addr;
        lo_n        = lo;
        abort_n     = abort;
        din_n       = ioctl_din;
        wait_n      = ioctl_wait;
        req_n       = mem_req;
        addr_n      = mem_addr;
        dirty_n     = nvram_dirty | cpu_cmos_we;

        case (state)
            IDLE: begin
                abort_n = 1'b0;
                if (ioctl_rd && active) begin
                    if (in_range) begin
                        state_n     = FETCH_LO;
                        byte_addr_n = ioctl_addr[BW-1:0];
                        addr_n      = {ioctl_addr[BW-1:0], 1'b0};
                        req_n       = 1'b1;
                        wait_n      = 1'b1;
                    end else begin
                        din_n = 8'hFF;
                    end
                end
            end

            // An upload that goes inactive still completes the pending handshake,
            // then drops the data and releases the HPS without touching ioctl_din.
            FETCH_LO: begin
                if (!active)
                    abort_n = 1'b1;
                if (ack) begin
                    lo_n = mem_rdata;
                    if (abort || !active) begin
                        state_n = IDLE;
                        req_n   = 1'b0;
                        wait_n  = 1'b0;
                    end else begin
                        state_n = FETCH_HI;
                        addr_n  = {byte_addr, 1'b1};
                    end
                end
            end

            FETCH_HI: begin
                if (!active)
                    abort_n = 1'b1;
                if (ack) begin
                    req_n = 1'b0;
                    if (abort || !active) begin
                        state_n = IDLE;
                        wait_n  = 1'b0;
                    end else begin
                        state_n = DONE;
                        din_n   = {mem_rdata, lo};
                    end
                end
            end

            DONE: begin
                state_n = IDLE;
                wait_n  = 1'b0;
                // A CPU write landing in this same cycle keeps the image dirty.
                if (byte_addr == '1 && !cpu_cmos_we)
                    dirty_n = 1'b0;
            end

            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_nvram_upload_server.sv
// Directed bench for nvram_upload_server: a CMOS memory with programmable ack
// delay, a transaction-level byte/latency model and a per-cycle output checker.
module tb_nvram_upload_server;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_upload;
    logic [15:0] ioctl_index;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        mem_req;
    logic [9:0]  mem_addr;
    logic        mem_ack;
    logic [3:0]  mem_rdata;
    logic        cpu_cmos_we;
    logic        nvram_dirty;

    nvram_upload_server #(.CELL_AW(10), .UPLOAD_INDEX(16'd4)) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .ioctl_upload(ioctl_upload),
        .ioctl_index (ioctl_index),
        .ioctl_rd    (ioctl_rd),
        .ioctl_addr  (ioctl_addr),
        .ioctl_din   (ioctl_din),
        .ioctl_wait  (ioctl_wait),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .cpu_cmos_we (cpu_cmos_we),
        .nvram_dirty (nvram_dirty)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;

    logic [3:0] cells [0:1023];
    int dlo = 0;
    int dhi = 0;
    int wcnt = 0;

    // Memory acks after `delay` extra req-high cycles at the current address.
    assign mem_ack   = mem_req && (wcnt == (mem_addr[0] ? dhi : dlo));
    assign mem_rdata = cells[mem_addr];

    always @(posedge clk_sys) begin
        if (!mem_req || mem_ack) wcnt <= 0;
        else                     wcnt <= wcnt + 1;
    end

    logic [7:0] exp_din   = 8'h00;
    logic       exp_dirty = 1'b0;
    bit         started   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic prev_req = 1'b0, prev_ack = 1'b0, prev_rst = 1'b1;
    always @(negedge clk_sys) begin
        if (started) begin
            chk("dirty", 32'(nvram_dirty), 32'(exp_dirty));
            if (!ioctl_wait)
                chk("din_hold", 32'(ioctl_din), 32'(exp_din));
            if (prev_req && !prev_ack && !prev_rst && !reset)
                chk("req_held_until_ack", 32'(mem_req), 32'd1);
        end
        prev_req = mem_req;
        prev_ack = mem_ack;
        prev_rst = reset;
    end

    task automatic pulse_we();
        @(posedge clk_sys); #1;
        cpu_cmos_we = 1'b1;
        @(posedge clk_sys); #1;
        cpu_cmos_we = 1'b0;
        exp_dirty = 1'b1;
    endtask

    // Wait-high length: lo fetch (1+dlo), hi fetch (1+dhi), one DONE cycle;
    // an abort skips DONE.
    task automatic do_read(input logic [24:0] addr, input int d_lo, input int d_hi,
                           input bit drop_in_hi, input bit we_in_done);
        logic [8:0]  a;
        logic [9:0]  acks [$];
        logic [7:0]  expb;
        int          cnt;
        int          exp_cnt;
        dlo = d_lo;
        dhi = d_hi;
        a = addr[8:0];
        @(posedge clk_sys); #1;
        ioctl_rd   = 1'b1;
        ioctl_addr = addr;
        @(posedge clk_sys); #1;
        ioctl_rd = 1'b0;
        if (addr >= 25'd512) begin
            exp_din = 8'hFF;
            chk("oor_wait", 32'(ioctl_wait), 32'd0);
            chk("oor_req", 32'(mem_req), 32'd0);
            chk("oor_din", 32'(ioctl_din), 32'hFF);
            return;
        end
        chk("rd_wait_rise", 32'(ioctl_wait), 32'd1);
        chk("rd_lo_addr", 32'(mem_addr), 32'({a, 1'b0}));
        expb = {cells[2*int'(a)+1], cells[2*int'(a)]};
        if (!drop_in_hi) exp_din = expb;
        exp_cnt = (drop_in_hi ? 2 : 3) + d_lo + d_hi;
        cnt = 0;
        if (mem_ack) acks.push_back(mem_addr);
        while (ioctl_wait && cnt < 200) begin
            @(posedge clk_sys); #1;
            cnt++;
            if (drop_in_hi && cnt == 1 + d_lo) ioctl_upload = 1'b0;
            if (we_in_done && cnt == 2 + d_lo + d_hi) cpu_cmos_we = 1'b1;
            if (we_in_done && cnt == 3 + d_lo + d_hi) cpu_cmos_we = 1'b0;
            if (ioctl_wait && mem_req && mem_ack) acks.push_back(mem_addr);
        end
        chk("wait_len", 32'(cnt), 32'(exp_cnt));
        chk("ack_count", 32'(acks.size()), 32'd2);
        if (acks.size() == 2) begin
            chk("ack_addr_lo", 32'(acks[0]), 32'({a, 1'b0}));
            chk("ack_addr_hi", 32'(acks[1]), 32'({a, 1'b1}));
        end
        chk("read_din", 32'(ioctl_din), 32'(exp_din));
        chk("read_req_idle", 32'(mem_req), 32'd0);
        if (drop_in_hi) ioctl_upload = 1'b1;
        if (!drop_in_hi && a == 9'd511 && !we_in_done) exp_dirty = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) cells[i] = 4'((i * 7 + 3) & 15);
        cells[0]    = 4'h3;
        cells[1]    = 4'hA;
        cells[1022] = 4'h1;
        cells[1023] = 4'hF;

        reset        = 1'b1;
        ioctl_upload = 1'b1;
        ioctl_index  = 16'd4;
        ioctl_rd     = 1'b0;
        ioctl_addr   = '0;
        cpu_cmos_we  = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        chk("rst_din", 32'(ioctl_din), 32'h00);
        chk("rst_wait", 32'(ioctl_wait), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_dirty", 32'(nvram_dirty), 32'd0);
        reset   = 1'b0;
        started = 1'b1;

        do_read(25'd0, 0, 0, 1'b0, 1'b0);
        chk("byte0_literal", 32'(ioctl_din), 32'hA3);

        do_read(25'h200, 0, 0, 1'b0, 1'b0);
        ioctl_din_pin: chk("oor_literal_200", 32'(ioctl_din), 32'hFF);
        do_read(25'h1FFFFFF, 0, 0, 1'b0, 1'b0);

        do_read(25'h1FF, 5, 5, 1'b0, 1'b0);
        chk("byte511_literal", 32'(ioctl_din), 32'hF1);

        ioctl_index = 16'd0;
        @(posedge clk_sys); #1;
        ioctl_rd   = 1'b1;
        ioctl_addr = 25'd0;
        @(posedge clk_sys); #1;
        ioctl_rd = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("idx0_wait", 32'(ioctl_wait), 32'd0);
            chk("idx0_req", 32'(mem_req), 32'd0);
            @(posedge clk_sys); #1;
        end
        ioctl_index = 16'd4;

        pulse_we();
        chk("dirty_set", 32'(nvram_dirty), 32'd1);
        for (int b = 0; b < 512; b++) do_read(25'(b), 0, 0, 1'b0, 1'b0);
        chk("dirty_cleared", 32'(nvram_dirty), 32'd0);

        pulse_we();
        for (int b = 0; b < 512; b++) do_read(25'(b), 0, 0, 1'b0, b == 511);
        chk("dirty_set_wins", 32'(nvram_dirty), 32'd1);

        do_read(25'd0, 0, 3, 1'b1, 1'b0);
        chk("abort_din_kept", 32'(ioctl_din), 32'hF1);
        chk("abort_dirty_kept", 32'(nvram_dirty), 32'd1);

        dlo = 3;
        dhi = 3;
        @(posedge clk_sys); #1;
        ioctl_rd   = 1'b1;
        ioctl_addr = 25'd0;
        @(posedge clk_sys); #1;
        ioctl_rd = 1'b0;
        chk("pre_rst_wait", 32'(ioctl_wait), 32'd1);
        reset = 1'b1;
        @(posedge clk_sys); #1;
        exp_din   = 8'h00;
        exp_dirty = 1'b0;
        chk("midrst_req", 32'(mem_req), 32'd0);
        chk("midrst_wait", 32'(ioctl_wait), 32'd0);
        chk("midrst_din", 32'(ioctl_din), 32'h00);
        chk("midrst_dirty", 32'(nvram_dirty), 32'd0);
        reset = 1'b0;

        do_read(25'd0, 0, 0, 1'b0, 1'b0);
        chk("post_rst_byte0", 32'(ioctl_din), 32'hA3);

        repeat (2) @(posedge clk_sys);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
